// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder cell and a carry flop reused
// over WIDTH cycles, LSB first. Results are registered and flagged by a
// one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state;
  logic [WIDTH-1:0]  a_sr;
  logic [WIDTH-1:0]  b_sr;
  logic [WIDTH-1:0]  s_sr;
  logic              c;
  logic [CntW-1:0]   cnt;

  logic              s_bit;
  logic              c_next;
  logic [WIDTH-1:0]  s_final;

  // Full-adder cell on the current LSBs; s_final is s_sr after this bit lands.
  always_comb begin
    s_bit   = a_sr[0] ^ b_sr[0] ^ c;
    c_next  = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    s_final = {s_bit, s_sr[WIDTH-1:1]};
  end

  // Control FSM, datapath shift registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        // The done cycle also accepts a new request, so back-to-back ops
        // issue every WIDTH+1 cycles.
        StIdle, StDone: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            c     <= sub;
            cnt   <= '0;
            state <= StRun;
            busy  <= 1'b1;
          end else begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        StRun: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          s_sr <= s_final;
          c    <= c_next;
          if (cnt == CntLast) begin
            // Carry into the MSB is the current c; overflow when it differs
            // from the carry out.
            state <= StDone;
            done  <= 1'b1;
            sum   <= s_final;
            carry <= c_next;
            ovf   <= c ^ c_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the functional and
// timing cases, and a 2-bit instance swept over every operand combination.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start8 = 1'b0;
  logic       sub8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       carry8;
  logic       ovf8;

  logic       start2 = 1'b0;
  logic       sub2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       carry2;
  logic       ovf2;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .sub   (sub8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .carry (carry8),
    .ovf   (ovf8)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .sub   (sub2),
    .a     (a2),
    .b     (b2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .carry (carry2),
    .ovf   (ovf2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the start edge until done8 is seen (bounded).
  task automatic wait_done8(output int lat);
    lat = 0;
    while (!done8 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op8(input logic s, input logic [7:0] x, input logic [7:0] y,
                         output int lat);
    sub8   = s;
    a8     = x;
    b8     = y;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8(lat);
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int done_cnt;
    int done_at;
    logic [1:0] bb;
    logic [2:0] r;
    logic       e_ovf;

    vecs[0] = '{1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};

    // Reset values, checked before any clock edge and while held.
    #1 rst = 1'b1;
    #1;
    check("rst_sum8", 32'(sum8), 32'h0);
    check("rst_carry8", 32'(carry8), 32'h0);
    check("rst_ovf8", 32'(ovf8), 32'h0);
    check("rst_busy8", 32'(busy8), 32'h0);
    check("rst_done8", 32'(done8), 32'h0);
    check("rst_busy2", 32'(busy2), 32'h0);
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    check("idle_busy8", 32'(busy8), 32'h0);

    // Single ADD with cycle-accurate busy/done profile.
    a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8   = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int i = 0; i < 14; i++) begin
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        done_at = i;
      end
      if (i == 8) begin
        check("t1_sum", 32'(sum8), 32'h10);
        check("t1_carry", 32'(carry8), 32'h0);
        check("t1_ovf", 32'(ovf8), 32'h0);
      end
      tick();
    end
    check("t1_busy_cycles", 32'(busy_cnt), 32'd9);
    check("t1_done_cycles", 32'(done_cnt), 32'd1);
    check("t1_done_latency", 32'(done_at), 32'd8);

    // Table-driven operations.
    for (int i = 0; i < 10; i++) begin
      run_op8(vecs[i].sub, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("v%0d_sum", i), 32'(sum8), 32'(vecs[i].sum));
      check($sformatf("v%0d_carry", i), 32'(carry8), 32'(vecs[i].carry));
      check($sformatf("v%0d_ovf", i), 32'(ovf8), 32'(vecs[i].ovf));
      tick();
      check($sformatf("v%0d_done_pulse", i), 32'(done8), 32'h0);
      tick();
    end

    // START held high, operands changed mid-run.
    a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'h33; b8 = 8'h11;
    wait_done8(lat);
    check("t4_latency", 32'(lat), 32'd8);
    check("t4_sum_first", 32'(sum8), 32'h10);
    tick();
    start8 = 1'b0;
    check("t4_done_cleared", 32'(done8), 32'h0);
    check("t4_reaccepted_busy", 32'(busy8), 32'h1);
    wait_done8(lat);
    check("t4_latency2", 32'(lat), 32'd8);
    check("t4_sum_second", 32'(sum8), 32'h44);
    tick();
    tick();

    // Asynchronous reset in the middle of a run.
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t5_busy_before", 32'(busy8), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t5_sum", 32'(sum8), 32'h0);
    check("t5_carry", 32'(carry8), 32'h0);
    check("t5_ovf", 32'(ovf8), 32'h0);
    check("t5_busy", 32'(busy8), 32'h0);
    check("t5_done", 32'(done8), 32'h0);
    #2 rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) done_cnt++;
    end
    check("t5_no_done", 32'(done_cnt), 32'd0);
    run_op8(1'b0, 8'h12, 8'h34, lat);
    check("t5_latency_after", 32'(lat), 32'd8);
    check("t5_sum_after", 32'(sum8), 32'h46);
    tick();

    // WIDTH=2: all 32 ops issued back-to-back.
    sub2 = 1'b0; a2 = 2'd0; b2 = 2'd0; start2 = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) begin
      logic [4:0] kk;
      logic [4:0] nk;
      kk = 5'(k);
      lat = 0;
      while (!done2 && lat < 20) begin
        tick();
        lat++;
      end
      check($sformatf("w2_op%0d_latency", k), 32'(lat), 32'd2);
      bb    = kk[4] ? ~kk[1:0] : kk[1:0];
      r     = {1'b0, kk[3:2]} + {1'b0, bb} + {2'b00, kk[4]};
      e_ovf = (kk[3] == bb[1]) && (r[1] != kk[3]);
      check($sformatf("w2_op%0d_sum", k), 32'(sum2), 32'(r[1:0]));
      check($sformatf("w2_op%0d_carry", k), 32'(carry2), 32'(r[2]));
      check($sformatf("w2_op%0d_ovf", k), 32'(ovf2), 32'(e_ovf));
      if (k < 31) begin
        nk   = 5'(k + 1);
        sub2 = nk[4];
        a2   = nk[3:2];
        b2   = nk[1:0];
      end else begin
        start2 = 1'b0;
      end
      tick();
      check($sformatf("w2_op%0d_done_pulse", k), 32'(done2), 32'h0);
      check($sformatf("w2_op%0d_busy_next", k), 32'(busy2), (k < 31) ? 32'h1 : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
